if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and drives the instruction-memory address. Instruction memory is an external combinational-read ROM.
- Each cycle it selects the next PC from the decode stage's redirect outputs (Z, J, JR, interrupt, exception) and the stall enable.
- Loads the 64-bit IF_ID pipeline register, injecting a NOP on flush. Also keeps fetch/flush performance counters.

---
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the program counter, drives the combinational instruction ROM address,
// picks the next PC from the decode-stage redirects and the stall enable, and
// loads the 64-bit IF_ID register ({PC+4, instruction}). A NOP is injected on
// any redirect. Saturating fetch/flush performance counters are kept here.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INT_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_IF_ID_Write,
  input  logic             Z,
  input  logic             J,
  input  logic             JR,
  input  logic             interrupt,
  input  logic             exception,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      jr_target,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst_data,
  output logic [63:0]      IF_ID,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [31:0]      RESET_PC_P4 = RESET_PC + 32'd4;
  localparam logic [63:0]      IF_ID_RST   = {RESET_PC_P4, NOP_INST};
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [31:0]      pc_q, pc_d;
  logic [63:0]      if_id_q, if_id_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [31:0] pc_inc;
  logic [31:0] redirect_pc_p4;
  logic        stall;
  logic        flush;
  logic        fetch_load;

  assign inst_addr   = pc_q;
  assign IF_ID       = if_id_q;
  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;

  assign stall = ~PC_IF_ID_Write;

  // Increment stays inside the current mode: the kernel bit is carried over
  // untouched and the low 31 bits wrap on their own.
  assign pc_inc = {pc_q[31], pc_q[30:0] + 31'd4};

  // Next-PC selection; interrupt/exception beat the stall because decode
  // squashes the stalled instruction itself when it takes a trap.
  always_comb begin
    pc_d  = pc_inc;
    flush = 1'b0;
    if (interrupt) begin
      pc_d  = INT_VEC;
      flush = 1'b1;
    end else if (exception) begin
      pc_d  = EXC_VEC;
      flush = 1'b1;
    end else if (stall) begin
      pc_d  = pc_q;
    end else if (JR) begin
      pc_d  = jr_target;
      flush = 1'b1;
    end else if (J) begin
      pc_d  = jump_target;
      flush = 1'b1;
    end else if (Z) begin
      pc_d  = branch_target;
      flush = 1'b1;
    end
  end

  assign redirect_pc_p4 = pc_d + 32'd4;
  assign fetch_load     = PC_IF_ID_Write & ~flush;

  // IF_ID next value: the injected NOP carries target+4 so a trap taken on
  // the bubble resumes at the redirect target, not on the wrong path.
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = {redirect_pc_p4, NOP_INST};
    end else if (fetch_load) begin
      if_id_d = {pc_inc, inst_data};
    end
  end

  // Saturating performance counters; both hold across a plain stall.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_load && (fetch_cnt_q != CNT_MAX)) begin
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF_ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= IF_ID_RST;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios with literal expectations,
// then randomized redirect/stall traffic, all compared every cycle against a
// behavioural fetch model.
module tb_if_stage;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          PC_IF_ID_Write = 1'b1;
  logic          Z = 1'b0, J = 1'b0, JR = 1'b0;
  logic          interrupt = 1'b0, exception = 1'b0;
  logic [31:0]   branch_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0]   inst_addr;
  logic [31:0]   inst_data;
  logic [63:0]   IF_ID;
  logic [CW-1:0] fetch_count, flush_count;

  logic [31:0]   rom_key = '0;

  int checks = 0;
  int errors = 0;

  if_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .PC_IF_ID_Write(PC_IF_ID_Write),
    .Z(Z), .J(J), .JR(JR), .interrupt(interrupt), .exception(exception),
    .branch_target(branch_target), .jump_target(jump_target),
    .jr_target(jr_target), .inst_addr(inst_addr), .inst_data(inst_data),
    .IF_ID(IF_ID), .fetch_count(fetch_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // ROM: word = address xor key (key 0 means ROM returns its address)
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ rom_key;
  endfunction

  assign inst_data = rom(inst_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned m_pc;
  longint unsigned m_ifid_pc, m_ifid_inst;
  int unsigned     m_fc, m_flc;
  localparam int unsigned CMAX = (1 << CW) - 1;

  always @(posedge clk or negedge rst_n) begin
    longint unsigned kbit, low, inc, tgt;
    bit redirect, stalled;
    if (!rst_n) begin
      m_pc        <= 64'h8000_0000;
      m_ifid_pc   <= 64'h8000_0004;
      m_ifid_inst <= 0;
      m_fc        <= 0;
      m_flc       <= 0;
    end else begin
      kbit = m_pc & 64'h8000_0000;
      low  = m_pc & 64'h7FFF_FFFF;
      inc  = kbit | ((low + 4) % 64'h8000_0000);
      stalled  = !PC_IF_ID_Write;
      redirect = 1;
      if (interrupt)      tgt = 64'h8000_0004;
      else if (exception) tgt = 64'h8000_0008;
      else if (stalled)   begin tgt = m_pc; redirect = 0; end
      else if (JR)        tgt = jr_target;
      else if (J)         tgt = jump_target;
      else if (Z)         tgt = branch_target;
      else                begin tgt = inc; redirect = 0; end
      m_pc <= tgt;
      if (redirect) begin
        m_ifid_pc   <= (tgt + 4) % 64'h1_0000_0000;
        m_ifid_inst <= 0;
        if (m_flc < CMAX) m_flc <= m_flc + 1;
      end else if (!stalled) begin
        m_ifid_pc   <= inc;
        m_ifid_inst <= rom(32'(m_pc));
        if (m_fc < CMAX) m_fc <= m_fc + 1;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("inst_addr",   {32'd0, inst_addr},     m_pc);
    chk("IF_ID",       IF_ID,                  {m_ifid_pc[31:0], m_ifid_inst[31:0]});
    chk("fetch_count", {{(64-CW){1'b0}}, fetch_count}, 64'(m_fc));
    chk("flush_count", {{(64-CW){1'b0}}, flush_count}, 64'(m_flc));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    PC_IF_ID_Write = 1'b1;
    Z = 0; J = 0; JR = 0; interrupt = 0; exception = 0;
  endtask

  task automatic go_to(input logic [31:0] a);
    idle(); J = 1; jump_target = a;
    tick();
    idle();
  endtask

  initial begin
    logic [63:0] held;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_pc",   {32'd0, inst_addr}, 64'h8000_0000);
    chk("rst_ifid", IF_ID, 64'h8000_0004_0000_0000);
    chk("rst_cnt",  {48'd0, fetch_count, flush_count}, 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // free run
    tick();
    chk("run1_ifid", IF_ID, 64'h8000_0004_8000_0000);
    tick();
    chk("run2_ifid", IF_ID, 64'h8000_0008_8000_0004);
    chk("run2_cnt",  {48'd0, fetch_count, flush_count}, {48'd0, 8'd2, 8'd0});

    // branch from 0x10 to 0x40
    go_to(32'h0000_0010);
    chk("at10", {32'd0, inst_addr}, 64'h10);
    Z = 1; branch_target = 32'h0000_0040;
    tick();
    idle();
    chk("br_ifid", IF_ID, 64'h0000_0044_0000_0000);
    chk("br_pc",   {32'd0, inst_addr}, 64'h40);
    tick();
    chk("br_next", IF_ID, 64'h0000_0044_0000_0040);
    chk("br_flc",  {56'd0, flush_count}, 64'd2);

    // stall with J pending
    held = IF_ID;
    PC_IF_ID_Write = 0; J = 1; jump_target = 32'h0000_0100;
    tick(); tick();
    chk("stall_pc",   {32'd0, inst_addr}, 64'h44);
    chk("stall_ifid", IF_ID, held);
    chk("stall_cnt",  {48'd0, fetch_count, flush_count}, {48'd0, 8'd3, 8'd2});
    PC_IF_ID_Write = 1;
    tick();
    idle();
    chk("rel_pc",   {32'd0, inst_addr}, 64'h100);
    chk("rel_ifid", IF_ID, 64'h0000_0104_0000_0000);

    // stall + interrupt at 0x20
    go_to(32'h0000_0020);
    PC_IF_ID_Write = 0; interrupt = 1;
    tick();
    idle();
    chk("int_pc",   {32'd0, inst_addr}, 64'h8000_0004);
    chk("int_ifid", IF_ID, 64'h8000_0008_0000_0000);
    tick();
    chk("int_next", IF_ID, 64'h8000_0008_8000_0004);

    // exception beats JR and Z
    exception = 1; JR = 1; jr_target = 32'h0000_0200; Z = 1; branch_target = 32'h0000_0300;
    tick();
    idle();
    chk("exc_pc",   {32'd0, inst_addr}, 64'h8000_0008);
    chk("exc_ifid", IF_ID, 64'h8000_000C_0000_0000);

    // kernel return via JR
    go_to(32'h8000_0030);
    JR = 1; jr_target = 32'h0000_0200;
    tick();
    idle();
    chk("jr_pc", {32'd0, inst_addr}, 64'h0000_0200);

    // user-mode wrap
    go_to(32'h7FFF_FFFC);
    tick();
    chk("wrap_pc",   {32'd0, inst_addr}, 64'h0);
    chk("wrap_ifid", IF_ID, 64'h0000_0000_7FFF_FFFC);

    // kernel-mode wrap keeps bit 31
    go_to(32'hFFFF_FFFC);
    tick();
    chk("kwrap_pc", {32'd0, inst_addr}, 64'h8000_0000);

    // async reset with a jump pending
    go_to(32'h0000_0500);
    J = 1; jump_target = 32'h0000_0600;
    #1 rst_n = 0;
    #1;
    chk("arst_pc",   {32'd0, inst_addr}, 64'h8000_0000);
    chk("arst_ifid", IF_ID, 64'h8000_0004_0000_0000);
    idle();
    #1 rst_n = 1;
    tick();
    chk("arst_after", {32'd0, inst_addr}, 64'h8000_0004);

    // randomized traffic
    rom_key = $urandom;
    for (int i = 0; i < 3000; i++) begin
      interrupt      = ($urandom_range(0, 31) == 0);
      exception      = ($urandom_range(0, 31) == 0);
      JR             = ($urandom_range(0, 9) == 0);
      J              = ($urandom_range(0, 7) == 0);
      Z              = ($urandom_range(0, 5) == 0);
      PC_IF_ID_Write = ($urandom_range(0, 4) != 0);
      branch_target  = $urandom;
      jump_target    = ($urandom_range(0, 15) == 0) ? 32'h7FFF_FFF8 : $urandom;
      jr_target      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
